// File: rtl/score_if.sv
// score_if: point/game event inputs and registered display outputs of score_keeper
interface score_if;
  logic game_start;
  logic game_over;
  logic add_1;
  logic add_5;
  logic [7:0] score;
  logic busy;
  logic new_record;
  modport master(output game_start, game_over, add_1, add_5, input score, busy, new_record);
  modport slave(input game_start, game_over, add_1, add_5, output score, busy, new_record);
endinterface

// File: rtl/score_keeper.sv
// score_keeper: saturating packed-BCD score with pending-point queue, high score and OVER display alternation
module score_keeper #(
  parameter int BLINK_W = 26
) (
  input logic clk,
  input logic rst,
  score_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, PLAY = 2'd1, DRAIN = 2'd2, OVER = 2'd3;
  logic [1:0] state, state_n;
  logic [7:0] cur, cur_n, high, high_n, pending, pending_n, cur_inc, score_n;
  logic [BLINK_W-1:0] alt_cnt, alt_cnt_n;
  logic alt_sel, alt_sel_n, rec, rec_n, sat, run, step;
  logic [3:0] inc;
  logic [8:0] sum;
  always_comb begin
    cur_inc = (cur[3:0] == 4'd9) ? {cur[7:4] + 4'd1, 4'd0} : {cur[7:4], cur[3:0] + 4'd1};
    sat = cur == 8'h99;
    run = state == PLAY || state == DRAIN;
    step = run && pending != 8'd0 && !sat;
    inc = (state == PLAY) ? {3'd0, bus.add_1} + (bus.add_5 ? 4'd5 : 4'd0) : 4'd0;
    sum = {1'b0, pending} + {5'd0, inc} - {8'd0, step};
    state_n = state;
    cur_n = cur;
    high_n = high;
    pending_n = pending;
    alt_cnt_n = alt_cnt;
    alt_sel_n = alt_sel;
    rec_n = rec;
    if (bus.game_start) begin
      state_n = PLAY;
      cur_n = 8'd0;
      pending_n = 8'd0;
      rec_n = 1'b0;
    end else if (run) begin
      cur_n = step ? cur_inc : cur;
      pending_n = sat ? 8'd0 : (sum > 9'd255 ? 8'd255 : sum[7:0]);
      if (state == PLAY && bus.game_over) state_n = DRAIN;
      // pending is 0 here, so cur is final and can be compared against high
      if (state == DRAIN && pending == 8'd0) begin
        state_n = OVER;
        high_n = (cur > high) ? cur : high;
        rec_n = cur > high;
        alt_cnt_n = '0;
        alt_sel_n = 1'b0;
      end
    end else if (state == OVER) begin
      alt_cnt_n = alt_cnt + 1'b1;
      alt_sel_n = alt_sel ^ (&alt_cnt);
    end
    score_n = (state_n == IDLE) ? high_n : (state_n == OVER && alt_sel_n) ? high_n : cur_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cur <= 8'd0;
      high <= 8'd0;
      pending <= 8'd0;
      alt_cnt <= '0;
      alt_sel <= 1'b0;
      rec <= 1'b0;
      bus.score <= 8'd0;
      bus.busy <= 1'b0;
    end else begin
      state <= state_n;
      cur <= cur_n;
      high <= high_n;
      pending <= pending_n;
      alt_cnt <= alt_cnt_n;
      alt_sel <= alt_sel_n;
      rec <= rec_n;
      bus.score <= score_n;
      bus.busy <= pending_n != 8'd0;
    end
  end
  assign bus.new_record = rec;
endmodule
